// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to instruction memory, buffers
// returned words with their PCs in a small prefetch FIFO, and flushes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_RDEN,
  output logic [13:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        DEC_READY,
  output logic        FD_VALID,
  output logic [31:0] FD_INSTR,
  output logic [31:0] FD_PC
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(QDEPTH);

  // Handshake: the head word transfers to decode in any cycle where
  // FD_VALID && DEC_READY; FD_INSTR/FD_PC stay stable while FD_VALID && !DEC_READY.

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_instr_q [QDEPTH];
  logic [31:0]   fifo_instr_d [QDEPTH];
  logic [31:0]   fifo_pc_q    [QDEPTH];
  logic [31:0]   fifo_pc_d    [QDEPTH];

  logic          redir;
  logic          pop;
  logic          push;
  logic          issue;
  logic [31:0]   redir_base;
  logic [CW:0]   occupancy;

  // A redirect is ignored while reset is held so the outputs stay quiet.
  assign redir      = REDIRECT && RST;
  assign redir_base = REDIRECT_PC & 32'hFFFF_FFFC;

  assign FD_VALID  = (count_q != '0) && !redir;
  assign FD_INSTR  = fifo_instr_q[rd_ptr_q];
  assign FD_PC     = fifo_pc_q[rd_ptr_q];
  assign pop       = FD_VALID && DEC_READY;
  assign push      = inflight_q && !redir;

  // Slots already committed (buffered plus the outstanding response) after this pop.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign issue     = RST && (redir || (occupancy < DEPTH_W));

  assign IMEM_RDEN = issue;
  assign IMEM_ADDR = redir ? REDIRECT_PC[15:2] : pc_q[15:2];

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = issue;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;

    if (redir) begin
      pc_d     = redir_base + 32'd4;
      req_pc_d = redir_base;
      count_d  = '0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = IMEM_DOUT;
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d               = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory returns word n at word address n; a PC-stream
// model predicts every delivered instruction and its PC.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_rden;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;

  int checks = 0;
  int errors = 0;

  logic        obs_valid;
  logic        obs_rden;
  logic [13:0] obs_addr;
  logic [31:0] obs_instr;
  logic [31:0] obs_pc;

  // Reference stream state: PC of the next word decode should see.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .CLK(clk),
    .RST(rst_n),
    .IMEM_RDEN(imem_rden),
    .IMEM_ADDR(imem_addr),
    .IMEM_DOUT(imem_dout),
    .REDIRECT(redirect),
    .REDIRECT_PC(redirect_pc),
    .DEC_READY(dec_ready),
    .FD_VALID(fd_valid),
    .FD_INSTR(fd_instr),
    .FD_PC(fd_pc)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: word n holds n, one cycle read latency.
  always @(posedge clk) begin
    if (imem_rden) imem_dout <= {18'h0, imem_addr};
  end

  // The FIFO must never receive a word while already full.
  always @(posedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut.push && (int'(dut.count_q) == QDEPTH)) begin
        errors++;
        $display("FAIL push_when_full t=%0t count=%0d push=%b required no push", $time, dut.count_q, dut.push);
      end
    end
  end

  // Driver: apply inputs just after the rising edge, sample at the falling edge.
  task automatic tick(input logic rst, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n       = rst;
    dec_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    obs_valid = fd_valid;
    obs_rden  = imem_rden;
    obs_addr  = imem_addr;
    obs_instr = fd_instr;
    obs_pc    = fd_pc;
  endtask

  task automatic reset_dut();
    tick(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b1, 1'b1, 32'h0000_1234);
      checks++;
      if (obs_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got=%b exp=0", obs_rden); end
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", obs_valid); end
      checks++;
      if (obs_addr !== RESET_PC[15:2]) begin errors++; $display("FAIL reset_addr got=%h exp=%h", obs_addr, RESET_PC[15:2]); end
      checks++;
      if (obs_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", obs_instr); end
      checks++;
      if (obs_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", obs_pc); end
    end
  endtask

  task automatic test_stream();
    reset_dut();
    exp_pc = RESET_PC;
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 0) begin
        checks++;
        if (obs_rden !== 1'b1 || obs_addr !== RESET_PC[15:2]) begin
          errors++; $display("FAIL stream_first_issue rden=%b addr=%h exp rden=1 addr=%h", obs_rden, obs_addr, RESET_PC[15:2]);
        end
      end
      if (k < 2) begin
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL stream_latency k=%0d valid=%b exp=0", k, obs_valid); end
      end else begin
        exp_instr = {18'h0, exp_pc[15:2]};
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          errors++; $display("FAIL stream_word k=%0d valid=%b pc=%h instr=%h exp pc=%h instr=%h", k, obs_valid, obs_pc, obs_instr, exp_pc, exp_instr);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    for (int s = 0; s < 5; s++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h8 || obs_instr !== 32'h2) begin
        errors++; $display("FAIL stall_hold s=%0d valid=%b pc=%h instr=%h exp pc=8 instr=2", s, obs_valid, obs_pc, obs_instr);
      end
      checks++;
      if (obs_rden !== 1'b0) begin errors++; $display("FAIL stall_rden s=%0d got=%b exp=0", s, obs_rden); end
      if (s == 4) begin
        checks++;
        if (int'(dut.count_q) != QDEPTH) begin errors++; $display("FAIL stall_full count=%0d exp=%0d", dut.count_q, QDEPTH); end
      end
    end
    exp_pc = 32'h8;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      exp_instr = {18'h0, exp_pc[15:2]};
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL stall_release k=%0d valid=%b pc=%h instr=%h exp pc=%h instr=%h", k, obs_valid, obs_pc, obs_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_pc !== 32'hC) begin errors++; $display("FAIL redir_pre pc=%h exp=c", obs_pc); end
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    checks++;
    if (obs_valid !== 1'b0 || obs_rden !== 1'b1 || obs_addr !== 14'h40) begin
      errors++; $display("FAIL redir_cycle valid=%b rden=%b addr=%h exp valid=0 rden=1 addr=40", obs_valid, obs_rden, obs_addr);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("FAIL redir_gap valid=%b exp=0", obs_valid); end
    exp_pc = 32'h100;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      exp_instr = {18'h0, exp_pc[15:2]};
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL redir_target k=%0d valid=%b pc=%h instr=%h exp pc=%h instr=%h", k, obs_valid, obs_pc, obs_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    checks++;
    if (obs_valid !== 1'b0 || obs_addr !== 14'h80) begin
      errors++; $display("FAIL b2b_first valid=%b addr=%h exp valid=0 addr=80", obs_valid, obs_addr);
    end
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    checks++;
    if (obs_valid !== 1'b0 || obs_addr !== 14'hC0) begin
      errors++; $display("FAIL b2b_second valid=%b addr=%h exp valid=0 addr=c0", obs_valid, obs_addr);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("FAIL b2b_stale valid=%b pc=%h exp valid=0", obs_valid, obs_pc); end
    exp_pc = 32'h300;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      exp_instr = {18'h0, exp_pc[15:2]};
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL b2b_stream k=%0d valid=%b pc=%h instr=%h exp pc=%h instr=%h", k, obs_valid, obs_pc, obs_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_valid !== 1'b0 || obs_rden !== 1'b0 || obs_instr !== 32'h0 || obs_pc !== 32'h0) begin
      errors++; $display("FAIL midrst_drop valid=%b rden=%b instr=%h pc=%h exp all 0", obs_valid, obs_rden, obs_instr, obs_pc);
    end
    exp_pc = RESET_PC;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 0) begin
        checks++;
        if (obs_rden !== 1'b1 || obs_addr !== RESET_PC[15:2]) begin
          errors++; $display("FAIL midrst_issue rden=%b addr=%h exp rden=1 addr=%h", obs_rden, obs_addr, RESET_PC[15:2]);
        end
      end
      if (k < 2) begin
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale k=%0d valid=%b pc=%h exp valid=0", k, obs_valid, obs_pc); end
      end else begin
        exp_instr = {18'h0, exp_pc[15:2]};
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          errors++; $display("FAIL midrst_restart k=%0d valid=%b pc=%h instr=%h exp pc=%h instr=%h", k, obs_valid, obs_pc, obs_instr, exp_pc, exp_instr);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_FFFC);
    checks++;
    if (obs_rden !== 1'b1 || obs_addr !== 14'h3FFF) begin
      errors++; $display("FAIL wrap_addr0 rden=%b addr=%h exp rden=1 addr=3fff", obs_rden, obs_addr);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_rden !== 1'b1 || obs_addr !== 14'h0000) begin
      errors++; $display("FAIL wrap_addr1 rden=%b addr=%h exp rden=1 addr=0000", obs_rden, obs_addr);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0000_FFFC || obs_instr !== 32'h3FFF) begin
      errors++; $display("FAIL wrap_word0 valid=%b pc=%h instr=%h exp pc=fffc instr=3fff", obs_valid, obs_pc, obs_instr);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0001_0000 || obs_instr !== 32'h0) begin
      errors++; $display("FAIL wrap_word1 valid=%b pc=%h instr=%h exp pc=10000 instr=0", obs_valid, obs_pc, obs_instr);
    end
  endtask

  task automatic test_random();
    int          since;
    int          accepted;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    reset_dut();
    exp_pc   = RESET_PC;
    since    = -1;
    accepted = 0;
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(3, 0) != 0);
      rd  = ($urandom_range(11, 0) == 0);
      rpc = $urandom;
      tick(1'b1, rdy, rd, rpc);
      if (rd) begin
        checks++;
        if (obs_valid !== 1'b0 || obs_rden !== 1'b1 || obs_addr !== rpc[15:2]) begin
          errors++; $display("FAIL rand_redir k=%0d valid=%b rden=%b addr=%h exp valid=0 rden=1 addr=%h", k, obs_valid, obs_rden, obs_addr, rpc[15:2]);
        end
        exp_pc = rpc & 32'hFFFF_FFFC;
        since  = 0;
      end else begin
        if (since < 3) since++;
        if (since == 2) begin
          checks++;
          if (obs_valid !== 1'b1) begin errors++; $display("FAIL rand_latency k=%0d valid=%b exp=1", k, obs_valid); end
        end
        if (obs_valid === 1'b1) begin
          exp_instr = {18'h0, exp_pc[15:2]};
          checks++;
          if (obs_pc !== exp_pc || obs_instr !== exp_instr) begin
            errors++; $display("FAIL rand_word k=%0d pc=%h instr=%h exp pc=%h instr=%h", k, obs_pc, obs_instr, exp_pc, exp_instr);
          end
          if (rdy) begin
            exp_pc = exp_pc + 32'd4;
            accepted++;
          end
        end
      end
    end
    checks++;
    if (accepted < 80) begin errors++; $display("FAIL rand_progress accepted=%0d exp>=80", accepted); end
  endtask

  initial begin
    rst_n       = 1'b1;
    dec_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #2 rst_n    = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
